sdram_cache: RTL and testbench
==============================

SDRAM_CACHE -- requirements
Module: sdram_cache

Interface
REQ-001 Parameters: LineIndexBitWidth, default 1, log2 of cache line count; RamAddressBitWidth, default 21, word-address width of backing SDRAM (max 21); RamAddressingMode, default 2, number of low CPU address bits dropped to form word address (2 = byte address, word aligned).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk in 1 clock; all state updates on rising edge.
REQ-004 rst in 1 async active-high reset; integrator drives it high until SDRAM controller init_done is high.
REQ-005 enable in 1 request valid; address in 32 CPU address; data_in in 32 write data; write_enable in 4 byte-lane write mask (0 = read).
REQ-006 data_out out 32 read word; data_out_ready out 1 read data valid; busy out 1 request not yet serviceable.
REQ-007 SDRAM controller side (names kept from controller): I_sdrc_cmd_en out 1; I_sdrc_cmd out 3; I_sdrc_precharge_ctrl out 1; I_sdram_power_down out 1; I_sdram_selfrefresh out 1; I_sdrc_addr out 21 {bank[1:0],row[10:0],col[7:0]}; I_sdrc_dqm out 4; I_sdrc_data out 32; I_sdrc_data_len out 8; O_sdrc_data in 32; O_sdrc_init_done in 1; O_sdrc_cmd_ack in 1.

Function
REQ-008 Direct-mapped, write-back, write-allocate; 2^LineIndexBitWidth lines of 8 words; per line: valid, dirty, tag, 8x32 data.
REQ-009 Word address w = address >> RamAddressingMode; offset = w[2:0]; index = w[3 +: LineIndexBitWidth]; tag = w[RamAddressBitWidth-1 : 3+LineIndexBitWidth].
REQ-010 hit = valid[index] && tag match; evaluated combinationally from address each cycle.
REQ-011 State encoding fixed: 0 Init, 1 InitRefresh, 2 Idle, 3 WbActivate, 4 WbWrite, 5 FillActivate, 6 FillRead, 7 FillData; verification probes state==2 as ready.
REQ-012 Init: issue Auto Refresh (cmd 3'b001, cmd_en 1 cycle), go InitRefresh; on cmd_ack go Idle.
REQ-013 Idle read hit (enable, write_enable==0): data_out = line word at offset, data_out_ready=1, busy=0, same cycle (combinational).
REQ-014 Idle write hit: on the clock edge write enabled byte lanes, set dirty; busy=0; no SDRAM access.
REQ-015 Miss in Idle or any non-Idle state: busy=1, data_out_ready=0.
REQ-016 Miss, victim valid&dirty: Active (3'b011, row/bank of victim), wait ack; Write (3'b100, col of victim line base, data_len=7), after ack drive victim words 0..7 on I_sdrc_data on 8 consecutive cycles; clear dirty.
REQ-017 Fill: Active (3'b011) for requested line, wait ack; Read (3'b101, col=line base, data_len=7); after ack, capture 8 consecutive O_sdrc_data words beginning 4 cycles after ack (controller CAS+pipeline latency) into words 0..7; set valid, tag, dirty=0; return Idle.
REQ-018 On return to Idle the pending request is a hit and completes per REQ-013/014 (write miss leaves line dirty).
REQ-019 cmd_en is a 1-cycle pulse per command; command held stable until ack; I_sdrc_precharge_ctrl=1 (auto precharge); power_down=0; selfrefresh=0; dqm=4'b0000.
REQ-020 I_sdrc_data_len=7 for all bursts; I_sdrc_addr col = word address[7:0], row = [18:8], bank = [20:19], upper bits zero when RamAddressBitWidth<21.
REQ-021 enable=0 in Idle: no state change, busy=0, data_out_ready=0.

Reset
REQ-022 While rst high: state=Init, all valid/dirty cleared, busy=1, data_out_ready=0, I_sdrc_cmd_en=0, I_sdrc_cmd=3'b111; data arrays not reset.
REQ-023 rst asserted mid-burst aborts immediately; no writeback of dirty data.

Verification
REQ-024 Config LineIndexBitWidth=1, RamAddressBitWidth=7; after rst release wait state==2; write data i to address 4*i for i=0..127 waiting on busy -> all writes accepted.
REQ-025 Read addr 4 -> next cycle busy=1, ready=0; wait ready -> data_out=1; then read addr 8 -> hit, ready=1, busy=0, data_out=2.
REQ-026 Write 0xabcd1234 to addr 4 -> busy=0 after one cycle; read addr 4 -> hit, data_out=0xabcd1234.
REQ-027 Read addr 64 -> miss, dirty eviction of line 0, data_out=16; read 12 -> data_out=3.
REQ-028 Write 0xf55e1234 to addr 64 -> busy=1, ready=0 until done; read 64 -> hit 0xf55e1234; read 4 -> miss, data_out=0xabcd1234; read 64 -> miss, data_out=0xf55e1234.

Source files
------------

// File: rtl/sdram_cache_if.sv
// CPU-side request bus of sdram_cache.
// The master drives a request and holds it until busy drops.
interface sdram_cache_if;
  logic        enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (
    output enable, address, data_in, write_enable,
    input  data_out, data_out_ready, busy
  );

  modport slave (
    input  enable, address, data_in, write_enable,
    output data_out, data_out_ready, busy
  );
endinterface

// File: rtl/sdram_cache.sv
// Direct-mapped write-back, write-allocate cache of 8-word lines in front of an SDRAM controller.
// Hits are served combinationally in Idle; misses evict (if dirty) and refill with 8-word bursts.
module sdram_cache #(
  parameter int LineIndexBitWidth  = 1,
  parameter int RamAddressBitWidth = 21,
  parameter int RamAddressingMode  = 2
) (
  input  logic         clk,
  input  logic         rst,
  sdram_cache_if.slave cpu,
  output logic         I_sdrc_cmd_en,
  output logic [2:0]   I_sdrc_cmd,
  output logic         I_sdrc_precharge_ctrl,
  output logic         I_sdram_power_down,
  output logic         I_sdram_selfrefresh,
  output logic [20:0]  I_sdrc_addr,
  output logic [3:0]   I_sdrc_dqm,
  output logic [31:0]  I_sdrc_data,
  output logic [7:0]   I_sdrc_data_len,
  input  logic [31:0]  O_sdrc_data,
  input  logic         O_sdrc_init_done,
  input  logic         O_sdrc_cmd_ack
);
  localparam int Lines = 1 << LineIndexBitWidth;
  localparam int TagW  = RamAddressBitWidth - 3 - LineIndexBitWidth;

  localparam logic [2:0] CMD_REFRESH = 3'b001;
  localparam logic [2:0] CMD_ACTIVE  = 3'b011;
  localparam logic [2:0] CMD_WRITE   = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;
  localparam logic [2:0] CMD_NOP     = 3'b111;

  typedef enum logic [2:0] {
    INIT          = 3'd0,
    INIT_REFRESH  = 3'd1,
    IDLE          = 3'd2,
    WB_ACTIVATE   = 3'd3,
    WB_WRITE      = 3'd4,
    FILL_ACTIVATE = 3'd5,
    FILL_READ     = 3'd6,
    FILL_DATA     = 3'd7
  } state_t;

  state_t state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic        burst_r, burst_n;
  logic        cmd_en_r, cmd_en_n;
  logic [2:0]  cmd_r, cmd_n;
  logic [20:0] addr_r, addr_n;

  logic [Lines-1:0] valid_r;
  logic [Lines-1:0] dirty_r;
  logic [TagW-1:0]  tag_mem_r [Lines];
  logic [31:0]      data_mem_r [Lines*8];

  logic [RamAddressBitWidth-1:0] word_addr_s;
  logic [2:0]                    offset_s;
  logic [LineIndexBitWidth-1:0]  index_s;
  logic [TagW-1:0]               tag_s;
  logic [20:0]                   req_base_s;
  logic [20:0]                   victim_base_s;
  logic [2:0]                    fill_off_s;
  logic hit_s, is_write_s, victim_dirty_s, cpu_write_s;
  logic fill_we_s, fill_done_s, wb_done_s;

  assign word_addr_s    = RamAddressBitWidth'(cpu.address >> RamAddressingMode);
  assign offset_s       = word_addr_s[2:0];
  assign index_s        = word_addr_s[3 +: LineIndexBitWidth];
  assign tag_s          = word_addr_s[RamAddressBitWidth-1 : 3+LineIndexBitWidth];
  assign req_base_s     = 21'({tag_s, index_s, 3'b000});
  assign victim_base_s  = 21'({tag_mem_r[index_s], index_s, 3'b000});
  assign hit_s          = valid_r[index_s] && (tag_mem_r[index_s] == tag_s);
  assign is_write_s     = (cpu.write_enable != 4'b0000);
  assign victim_dirty_s = valid_r[index_s] && dirty_r[index_s];
  assign cpu_write_s    = (state_r == IDLE) && cpu.enable && hit_s && is_write_s;
  // Read data lands 4 cycles after the Read ack, so words arrive while cnt runs 3..10.
  assign fill_off_s     = 3'(cnt_r - 4'd3);

  assign cpu.data_out       = data_mem_r[{index_s, offset_s}];
  assign cpu.data_out_ready = (state_r == IDLE) && cpu.enable && hit_s && !is_write_s;
  assign cpu.busy           = !((state_r == IDLE) && (!cpu.enable || hit_s));

  assign I_sdrc_cmd_en         = cmd_en_r;
  assign I_sdrc_cmd            = cmd_r;
  assign I_sdrc_addr           = addr_r;
  assign I_sdrc_precharge_ctrl = 1'b1;
  assign I_sdram_power_down    = 1'b0;
  assign I_sdram_selfrefresh   = 1'b0;
  assign I_sdrc_dqm            = 4'b0000;
  assign I_sdrc_data_len       = 8'd7;
  assign I_sdrc_data = (state_r == WB_WRITE && burst_r) ? data_mem_r[{index_s, cnt_r[2:0]}] : 32'h0;

  // Next-state and command sequencing; a command's cmd_en is a single-cycle pulse.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    burst_n     = burst_r;
    cmd_en_n    = 1'b0;
    cmd_n       = cmd_r;
    addr_n      = addr_r;
    fill_we_s   = 1'b0;
    fill_done_s = 1'b0;
    wb_done_s   = 1'b0;
    case (state_r)
      INIT: begin
        if (O_sdrc_init_done) begin
          state_n  = INIT_REFRESH;
          cmd_en_n = 1'b1;
          cmd_n    = CMD_REFRESH;
        end else begin
          state_n = INIT;
        end
      end
      INIT_REFRESH: begin
        if (O_sdrc_cmd_ack) begin
          state_n = IDLE;
          cmd_n   = CMD_NOP;
        end else begin
          state_n = INIT_REFRESH;
        end
      end
      IDLE: begin
        if (cpu.enable && !hit_s) begin
          cmd_en_n = 1'b1;
          cmd_n    = CMD_ACTIVE;
          if (victim_dirty_s) begin
            state_n = WB_ACTIVATE;
            addr_n  = victim_base_s;
          end else begin
            state_n = FILL_ACTIVATE;
            addr_n  = req_base_s;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WB_ACTIVATE: begin
        if (O_sdrc_cmd_ack) begin
          state_n  = WB_WRITE;
          cmd_en_n = 1'b1;
          cmd_n    = CMD_WRITE;
          burst_n  = 1'b0;
        end else begin
          state_n = WB_ACTIVATE;
        end
      end
      WB_WRITE: begin
        if (burst_r) begin
          cnt_n = cnt_r + 4'd1;
          if (cnt_r == 4'd7) begin
            burst_n   = 1'b0;
            wb_done_s = 1'b1;
            state_n   = FILL_ACTIVATE;
            cmd_en_n  = 1'b1;
            cmd_n     = CMD_ACTIVE;
            addr_n    = req_base_s;
          end else begin
            state_n = WB_WRITE;
          end
        end else if (O_sdrc_cmd_ack) begin
          burst_n = 1'b1;
          cnt_n   = 4'd0;
          cmd_n   = CMD_NOP;
        end else begin
          state_n = WB_WRITE;
        end
      end
      FILL_ACTIVATE: begin
        if (O_sdrc_cmd_ack) begin
          state_n  = FILL_READ;
          cmd_en_n = 1'b1;
          cmd_n    = CMD_READ;
        end else begin
          state_n = FILL_ACTIVATE;
        end
      end
      FILL_READ: begin
        if (O_sdrc_cmd_ack) begin
          state_n = FILL_DATA;
          cnt_n   = 4'd0;
          cmd_n   = CMD_NOP;
        end else begin
          state_n = FILL_READ;
        end
      end
      FILL_DATA: begin
        cnt_n = cnt_r + 4'd1;
        if (cnt_r >= 4'd3) begin
          fill_we_s = 1'b1;
        end else begin
          fill_we_s = 1'b0;
        end
        if (cnt_r == 4'd10) begin
          fill_done_s = 1'b1;
          state_n     = IDLE;
        end else begin
          state_n = FILL_DATA;
        end
      end
      default: state_n = INIT;
    endcase
  end

  // FSM and command registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= INIT;
      cnt_r    <= 4'd0;
      burst_r  <= 1'b0;
      cmd_en_r <= 1'b0;
      cmd_r    <= CMD_NOP;
      addr_r   <= 21'd0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      burst_r  <= burst_n;
      cmd_en_r <= cmd_en_n;
      cmd_r    <= cmd_n;
      addr_r   <= addr_n;
    end
  end

  // Line status bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {Lines{1'b0}};
      dirty_r <= {Lines{1'b0}};
    end else if (fill_done_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (wb_done_s) begin
      dirty_r[index_s] <= 1'b0;
    end else if (cpu_write_s) begin
      dirty_r[index_s] <= 1'b1;
    end
  end

  // Tag and data storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_mem_r[{index_s, fill_off_s}] <= O_sdrc_data;
    end else if (cpu_write_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu.write_enable[b]) begin
          data_mem_r[{index_s, offset_s}][8*b +: 8] <= cpu.data_in[8*b +: 8];
        end
      end
    end
    if (fill_done_s) begin
      tag_mem_r[index_s] <= tag_s;
    end
  end
endmodule

// File: tb/tb_sdram_cache.sv
// Self-checking bench for sdram_cache: SDRAM controller model, directed vector table,
// randomized accesses against a flat-memory reference, and a mid-burst reset.
module tb_sdram_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_cache_if bus ();

  logic        cmd_en, pre_ctrl, pwr_down, self_ref, init_done, cmd_ack;
  logic [2:0]  cmd;
  logic [20:0] sd_addr;
  logic [3:0]  dqm;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  data_len;

  sdram_cache #(.LineIndexBitWidth(1), .RamAddressBitWidth(7), .RamAddressingMode(2)) dut (
    .clk(clk), .rst(rst), .cpu(bus.slave),
    .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd), .I_sdrc_precharge_ctrl(pre_ctrl),
    .I_sdram_power_down(pwr_down), .I_sdram_selfrefresh(self_ref), .I_sdrc_addr(sd_addr),
    .I_sdrc_dqm(dqm), .I_sdrc_data(wr_data), .I_sdrc_data_len(data_len),
    .O_sdrc_data(rd_data), .O_sdrc_init_done(init_done), .O_sdrc_cmd_ack(cmd_ack)
  );

  int chk = 0;
  int err = 0;

  // SDRAM controller model: ack 3 cycles after cmd_en, write data taken on the 8 cycles
  // after ack, read data driven from the 4th cycle after ack.
  logic [31:0] sdram [128];
  logic        seeded = 1'b0;
  logic        prev_cmd_en;
  logic [2:0]  op;
  int op_base, ack_wait, ph = -1;
  int wr_words = 0, proto_seen = 0, proto_bad = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ack <= 1'b0;
      ack_wait = 0;
      ph = -1;
      prev_cmd_en = 1'b0;
      if (!seeded) begin
        for (int i = 0; i < 128; i++) sdram[i] = $urandom;
        seeded = 1'b1;
      end
    end else begin
      cmd_ack <= 1'b0;
      rd_data <= $urandom;
      if (ph >= 0) begin
        ph++;
        if (op == 3'b100 && ph >= 2 && ph <= 9) begin
          sdram[(op_base + ph - 2) & 127] = wr_data;
          wr_words++;
        end
        if (op == 3'b101 && ph >= 4 && ph <= 11) rd_data <= sdram[(op_base + ph - 4) & 127];
        if (ph >= 12) ph = -1;
      end
      if (cmd_en) begin
        proto_seen++;
        if ({prev_cmd_en, pre_ctrl, pwr_down, self_ref, dqm, data_len, sd_addr[20:7]} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd7, 14'h0}) proto_bad++;
        if ((cmd == 3'b100 || cmd == 3'b101) && sd_addr[2:0] != 3'd0) proto_bad++;
        op = cmd;
        op_base = int'(sd_addr[6:0]);
        ack_wait = 2;
      end else if (ack_wait == 1) begin
        cmd_ack <= 1'b1;
        ack_wait = 0;
        ph = 0;
      end else if (ack_wait > 1) begin
        ack_wait--;
      end
      prev_cmd_en = cmd_en;
    end
  end

  // Reference: flat word memory plus which 8-word block each of the 2 lines holds.
  logic [31:0] ref_mem [128];
  int ref_blk [2];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] data;
    logic        hit;
  } vec_t;

  logic [31:0] acc_data;
  logic acc_ready, acc_busy0, acc_ready0;
  int acc_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic predict(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we,
                         output logic hit, output logic [31:0] rd);
    int w, blk;
    w = int'((addr >> 2) & 32'h7f);
    blk = w / 8;
    hit = (ref_blk[blk % 2] == blk);
    ref_blk[blk % 2] = blk;
    for (int b = 0; b < 4; b++) if (we[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    rd = ref_mem[w];
  endtask

  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    acc_wait = 0;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.address = addr;
    bus.data_in = wdata;
    bus.write_enable = we;
    #1;
    acc_busy0 = bus.busy;
    acc_ready0 = bus.data_out_ready;
    while (bus.busy && acc_wait < 200) begin
      @(negedge clk);
      #1;
      acc_wait++;
    end
    check("accepted_in_budget", 32'(bus.busy), 32'd0);
    acc_data = bus.data_out;
    acc_ready = bus.data_out_ready;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.write_enable = 4'h0;
  endtask

  task automatic checked_access(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] we, input string name);
    logic eh;
    logic [31:0] ed;
    predict(addr, wdata, we, eh, ed);
    access(addr, wdata, we);
    check({name, "_hit"}, 32'(acc_wait == 0), 32'(eh));
    if (!eh) check({name, "_miss_flags"}, 32'({acc_busy0, acc_ready0}), 32'h2);
    check({name, "_ready"}, 32'(acc_ready), 32'(we == 4'h0));
    if (we == 4'h0) check({name, "_data"}, acc_data, ed);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (dut.state_r != 3'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dut.state_r), 32'd2);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    check({name, "_ready"}, 32'(bus.data_out_ready), 32'd0);
    check({name, "_cmd_en"}, 32'(cmd_en), 32'd0);
    check({name, "_cmd"}, 32'(cmd), 32'd7);
    check({name, "_state"}, 32'(dut.state_r), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", chk, err);
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    logic eh;
    logic [31:0] ed;
    int w, last_w, base;
    logic [31:0] a;

    vecs[0] = '{32'd4,   32'h0,         4'h0, 32'd1,         1'b0};
    vecs[1] = '{32'd8,   32'h0,         4'h0, 32'd2,         1'b1};
    vecs[2] = '{32'd4,   32'habcd1234,  4'hf, 32'h0,         1'b1};
    vecs[3] = '{32'd4,   32'h0,         4'h0, 32'habcd1234,  1'b1};
    vecs[4] = '{32'd64,  32'h0,         4'h0, 32'd16,        1'b0};
    vecs[5] = '{32'd12,  32'h0,         4'h0, 32'd3,         1'b0};
    vecs[6] = '{32'd64,  32'hf55e1234,  4'hf, 32'h0,         1'b0};
    vecs[7] = '{32'd64,  32'h0,         4'h0, 32'hf55e1234,  1'b1};
    vecs[8] = '{32'd4,   32'h0,         4'h0, 32'habcd1234,  1'b0};
    vecs[9] = '{32'd64,  32'h0,         4'h0, 32'hf55e1234,  1'b0};

    bus.enable = 1'b0;
    bus.address = 32'h0;
    bus.data_in = 32'h0;
    bus.write_enable = 4'h0;
    init_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 128; i++) ref_mem[i] = sdram[i];
    ref_blk[0] = -1;
    ref_blk[1] = -1;
    check_reset_outputs("rst");
    init_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle("init_idle");

    // Fill the whole 128-word SDRAM through the cache: word i holds i.
    for (int i = 0; i < 128; i++) begin
      predict(32'(4 * i), 32'(i), 4'hf, eh, ed);
      access(32'(4 * i), 32'(i), 4'hf);
    end

    for (int i = 0; i < 10; i++) begin
      predict(vecs[i].addr, vecs[i].wdata, vecs[i].we, eh, ed);
      access(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      check($sformatf("vec%0d_hit", i), 32'(acc_wait == 0), 32'(vecs[i].hit));
      if (!vecs[i].hit) check($sformatf("vec%0d_miss_flags", i), 32'({acc_busy0, acc_ready0}), 32'h2);
      if (vecs[i].we == 4'h0) begin
        check($sformatf("vec%0d_ready", i), 32'(acc_ready), 32'd1);
        check($sformatf("vec%0d_data", i), acc_data, vecs[i].data);
      end else begin
        check($sformatf("vec%0d_ready", i), 32'(acc_ready), 32'd0);
      end
    end

    // Random traffic; upper and low address bits beyond the word address are don't-care.
    last_w = 0;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 1) == 1) w = (last_w & ~7) | int'($urandom_range(0, 7));
      else w = int'($urandom_range(0, 127));
      last_w = w;
      a = ($urandom & 32'hffff_fe03) | (32'(w) << 2);
      if ($urandom_range(0, 1) == 1) checked_access(a, $urandom, 4'h0, "rnd_rd");
      else checked_access(a, $urandom, 4'($urandom_range(1, 15)), "rnd_wr");
    end

    // Reset in the middle of a dirty eviction burst.
    checked_access(32'h0, 32'h1111_2222, 4'hf, "pre_rst_wr");
    base = wr_words;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.address = 32'h100;
    bus.write_enable = 4'h0;
    for (int n = 0; n < 100 && wr_words < base + 3; n++) @(negedge clk);
    check("burst_started", 32'(wr_words >= base + 3), 32'd1);
    rst = 1'b1;
    bus.enable = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    base = wr_words;
    repeat (20) @(negedge clk);
    check("no_wb_after_rst", 32'(wr_words - base), 32'd0);
    for (int i = 0; i < 128; i++) ref_mem[i] = sdram[i];
    ref_blk[0] = -1;
    ref_blk[1] = -1;
    rst = 1'b0;
    wait_idle("rst_idle");
    checked_access(32'h0, 32'h0, 4'h0, "post_rst_rd0");
    checked_access(32'h100, 32'h0, 4'h0, "post_rst_rd64");
    checked_access(32'h24, 32'h0, 4'h0, "post_rst_rd9");

    check("sdrc_cmd_seen", 32'(proto_seen > 0), 32'd1);
    check("sdrc_cmd_protocol_bad", 32'(proto_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
